// File: rtl/pc_fetch_pkg.sv
// rtl/pc_fetch_pkg.sv - shared defines for the fetch stage and next-PC unit
//
// Purpose : fetch FSM state encodings, reset defaults, NPC_* opcodes and a
//           small alignment helper shared by the fetch stage and its users.
// Ports   : none (package).

package pc_fetch_pkg;

   // Default first fetch address after reset.
   localparam logic [31:0] PC_FETCH_RESET_PC = 32'h0000_0000;

   // Instruction presented while nothing has been fetched yet (addi x0,x0,0).
   localparam logic [31:0] PC_FETCH_NOP = 32'h0000_0013;

   // Fetch FSM states.
   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_ERR   = 2'd3
   } fetch_state_e;

   // Next-PC unit opcodes; they select how npc is formed upstream.
   typedef enum logic [2:0] {
      NPC_SEQ    = 3'd0,
      NPC_BRANCH = 3'd1,
      NPC_JAL    = 3'd2,
      NPC_JALR   = 3'd3,
      NPC_TRAP   = 3'd4
   } npc_op_e;

   // Instructions are word aligned; anything else is a fetch error.
   function automatic logic pc_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - instruction memory and downstream handshake bundle
//
// Purpose : groups the instruction-memory read channel, the downstream
//           pc/inst handshake, the next-PC input and the status outputs.
// Signals : npc         next PC for the presented instruction
//           imem_req    instruction-memory read request
//           imem_addr   instruction-memory read address
//           imem_rvalid instruction-memory read data valid
//           imem_rdata  instruction-memory read data
//           pc          address of the presented instruction
//           inst        presented instruction word
//           inst_valid  pc/inst valid for the downstream stage
//           inst_ready  downstream accepts pc/inst this cycle
//           fetch_err   sticky misaligned-npc error flag
//           fetch_cnt   count of instructions accepted downstream
// Modports: master = fetch stage, slave = memory/downstream/next-PC side.

interface pc_fetch_if;

   logic [31:0] npc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        inst_valid;
   logic        inst_ready;
   logic        fetch_err;
   logic [31:0] fetch_cnt;

   modport master (
      input  npc,
      output imem_req,
      output imem_addr,
      input  imem_rvalid,
      input  imem_rdata,
      output pc,
      output inst,
      output inst_valid,
      input  inst_ready,
      output fetch_err,
      output fetch_cnt
   );

   modport slave (
      output npc,
      input  imem_req,
      input  imem_addr,
      output imem_rvalid,
      output imem_rdata,
      input  pc,
      input  inst,
      input  inst_valid,
      output inst_ready,
      input  fetch_err,
      input  fetch_cnt
   );

endinterface

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - program counter and instruction fetch stage
//
// Purpose : holds the PC, issues one instruction-memory read per
//           instruction, presents pc/inst downstream and advances to npc on
//           acceptance. A misaligned npc parks the stage in an absorbing
//           error state until reset.
// Ports   : clk   sole clock, rising edge
//           rst_n asynchronous active-low reset
//           bus   pc_fetch_if.master (memory, downstream, npc, status)
// Params  : RESET_PC first fetch address after reset

module pc_fetch
   import pc_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = PC_FETCH_RESET_PC
) (
   input  logic       clk,
   input  logic       rst_n,
   pc_fetch_if.master bus
);

   fetch_state_e state_q;
   fetch_state_e state_d;

   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [31:0] cnt_q;

   logic pc_load;
   logic inst_load;
   logic cnt_inc;
   logic req;
   logic valid;
   logic err;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and controls. req/valid/err depend on state_q only, so the
   // memory request and downstream valid never combinationally follow an
   // input.
   always_comb begin
      state_d   = state_q;
      pc_load   = 1'b0;
      inst_load = 1'b0;
      cnt_inc   = 1'b0;
      req       = 1'b0;
      valid     = 1'b0;
      err       = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            req = 1'b1;
            if (bus.imem_rvalid) begin
               inst_load = 1'b1;
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            valid = 1'b1;
            if (bus.inst_ready) begin
               // The instruction is consumed either way; only the next PC
               // is rejected when misaligned.
               cnt_inc = 1'b1;
               if (pc_aligned(bus.npc)) begin
                  pc_load = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_ERR: begin
            err     = 1'b1;
            state_d = ST_ERR;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         inst_q <= PC_FETCH_NOP;
         cnt_q  <= 32'h0000_0000;
      end else begin
         if (pc_load) begin
            pc_q <= bus.npc;
         end
         if (inst_load) begin
            inst_q <= bus.imem_rdata;
         end
         if (cnt_inc) begin
            cnt_q <= cnt_q + 32'h0000_0001;
         end
      end
   end

   assign bus.imem_req   = req;
   assign bus.imem_addr  = pc_q;
   assign bus.pc         = pc_q;
   assign bus.inst       = inst_q;
   assign bus.inst_valid = valid;
   assign bus.fetch_err  = err;
   assign bus.fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - self-checking bench for pc_fetch

module tb_pc_fetch;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   pc_fetch_if bus ();

   pc_fetch dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_pc;
   logic [31:0] m_inst;
   logic [31:0] m_cnt;
   logic        m_err;
   logic [63:0] sb_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},   {31'd0, bus.imem_req},   32'd0);
      chk({tag, "_valid"}, {31'd0, bus.inst_valid}, 32'd0);
      chk({tag, "_err"},   {31'd0, bus.fetch_err},  32'd0);
      chk({tag, "_pc"},    bus.pc,                  32'h0000_0000);
      chk({tag, "_inst"},  bus.inst,                32'h0000_0013);
      chk({tag, "_cnt"},   bus.fetch_cnt,           32'h0000_0000);
   endtask

   // Pulse reset off a clock edge, check the asynchronous response, then
   // release and check the single BOOT cycle and the first request.
   task automatic apply_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs({tag, "_async"});
      m_pc   = 32'h0000_0000;
      m_inst = 32'h0000_0013;
      m_cnt  = 32'h0000_0000;
      m_err  = 1'b0;
      sb_q.delete();
      // Stray memory data and accepts around reset must all be ignored.
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      bus.inst_ready  = 1'b1;
      bus.npc         = 32'h0000_0200;
      @(negedge clk);
      chk_reset_outputs({tag, "_held"});
      rst_n = 1'b1;
      #1;
      chk({tag, "_boot_req"}, {31'd0, bus.imem_req}, 32'd0);
      @(negedge clk);
      chk({tag, "_first_req"},  {31'd0, bus.imem_req}, 32'd1);
      chk({tag, "_first_addr"}, bus.imem_addr, 32'h0000_0000);
      chk({tag, "_boot_inst"},  bus.inst, 32'h0000_0013);
      bus.imem_rvalid = 1'b0;
      bus.inst_ready  = 1'b0;
   endtask

   // One instruction: wait for the request, answer after lat wait cycles,
   // stall downstream for hold cycles, then accept with next_pc.
   task automatic do_fetch(input int lat, input logic [31:0] data,
                           input int hold, input logic [31:0] next_pc);
      logic [63:0] exp;
      int waited;
      waited = 0;
      while (bus.imem_req !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("req_seen", {31'd0, bus.imem_req}, 32'd1);
      chk("fetch_addr", bus.imem_addr, m_pc);
      chk("no_valid_in_fetch", {31'd0, bus.inst_valid}, 32'd0);
      for (int i = 0; i < lat; i++) begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = $urandom;
         bus.inst_ready  = 1'b1;
         bus.npc         = $urandom;
         @(negedge clk);
         chk("addr_hold", bus.imem_addr, m_pc);
         chk("req_hold", {31'd0, bus.imem_req}, 32'd1);
         chk("inst_wait", bus.inst, m_inst);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = data;
      bus.inst_ready  = 1'b0;
      sb_q.push_back({m_pc, data});
      @(negedge clk);
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      chk("valid_in_hold", {31'd0, bus.inst_valid}, 32'd1);
      chk("req_in_hold", {31'd0, bus.imem_req}, 32'd0);
      chk("sb_depth", sb_q.size(), 32'd1);
      if (sb_q.size() != 0) begin
         exp = sb_q.pop_front();
         chk("hold_pc", bus.pc, exp[63:32]);
         chk("hold_inst", bus.inst, exp[31:0]);
      end
      m_inst = data;
      for (int i = 0; i < hold; i++) begin
         bus.inst_ready  = 1'b0;
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = $urandom;
         bus.npc         = $urandom;
         @(negedge clk);
         chk("stall_pc", bus.pc, m_pc);
         chk("stall_inst", bus.inst, m_inst);
         chk("stall_valid", {31'd0, bus.inst_valid}, 32'd1);
         chk("stall_req", {31'd0, bus.imem_req}, 32'd0);
      end
      bus.imem_rvalid = 1'b0;
      bus.inst_ready  = 1'b1;
      bus.npc         = next_pc;
      @(negedge clk);
      bus.inst_ready = 1'b0;
      bus.npc        = $urandom;
      m_cnt = m_cnt + 32'd1;
      if (next_pc[1:0] == 2'b00) m_pc = next_pc;
      else m_err = 1'b1;
      chk("fetch_cnt", bus.fetch_cnt, m_cnt);
      chk("fetch_err", {31'd0, bus.fetch_err}, {31'd0, m_err});
      chk("pc_after", bus.pc, m_pc);
      chk("valid_after", {31'd0, bus.inst_valid}, 32'd0);
   endtask

   initial begin
      rst_n           = 1'b1;
      bus.npc         = 32'h0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      bus.inst_ready  = 1'b0;

      apply_reset("por");

      // Zero-wait memory, always-ready downstream, sequential npc.
      do_fetch(0, 32'h0010_0093, 0, 32'h0000_0004);
      do_fetch(0, 32'h0010_0093, 0, 32'h0000_0008);
      do_fetch(0, 32'h0010_0093, 0, 32'h0000_000C);
      chk("cnt_after_three", bus.fetch_cnt, 32'd3);

      // Memory answers three cycles after the request.
      do_fetch(3, 32'hA5A5_0013, 0, 32'h0000_0010);

      // Downstream stall, then a jump.
      do_fetch(0, 32'h1234_5678, 5, 32'h0000_0100);
      do_fetch(1, 32'h0000_0063, 0, 32'h0000_0104);

      // Counter wrap.
      force dut.cnt_q = 32'hFFFF_FFFE;
      #1 release dut.cnt_q;
      m_cnt = 32'hFFFF_FFFE;
      do_fetch(0, 32'h0000_1111, 0, 32'h0000_0108);
      do_fetch(0, 32'h0000_2222, 0, 32'h0000_010C);

      // Reset in the middle of a pending fetch.
      chk("pre_reset_req", {31'd0, bus.imem_req}, 32'd1);
      apply_reset("rst_fetch");
      do_fetch(2, 32'h0000_3333, 0, 32'h0000_0004);

      // Misaligned npc: error state is absorbing.
      do_fetch(0, 32'h0000_4444, 0, 32'h0000_0102);
      for (int i = 0; i < 6; i++) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = $urandom;
         bus.inst_ready  = 1'b1;
         bus.npc         = 32'h0000_0040;
         @(negedge clk);
         chk("err_req", {31'd0, bus.imem_req}, 32'd0);
         chk("err_valid", {31'd0, bus.inst_valid}, 32'd0);
         chk("err_flag", {31'd0, bus.fetch_err}, 32'd1);
         chk("err_cnt", bus.fetch_cnt, m_cnt);
         chk("err_pc", bus.pc, m_pc);
         chk("err_inst", bus.inst, m_inst);
      end

      // Reset out of the error state.
      apply_reset("rst_err");
      do_fetch(0, 32'h0000_5555, 0, 32'h0000_0004);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port npc  input  32  next PC from the next-PC unit for the instruction currently presented.
REQ-005 The block SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 The block SHALL have port imem_addr  output  32  instruction-memory read address.
REQ-007 The block SHALL have port imem_rvalid  input  1  instruction-memory read data valid.
REQ-008 The block SHALL have port imem_rdata  input  32  instruction-memory read data.
REQ-009 The block SHALL have port pc  output  32  address of the presented instruction.
REQ-010 The block SHALL have port inst  output  32  presented instruction word.
REQ-011 The block SHALL have port inst_valid  output  1  pc/inst valid for the downstream stage.
REQ-012 The block SHALL have port inst_ready  input  1  downstream accepts pc/inst this cycle.
REQ-013 The block SHALL have port fetch_err  output  1  sticky misaligned-npc error flag.
REQ-014 The block SHALL have port fetch_cnt  output  32  count of instructions accepted downstream.

Function
REQ-015 The block SHALL implement states BOOT, FETCH, HOLD and ERR.
REQ-016 BOOT SHALL last exactly one cycle after rst_n deasserts, then go to FETCH.
REQ-017 In FETCH: imem_req=1 and imem_addr=pc; both SHALL stay stable until a cycle with imem_rvalid=1.
REQ-018 In FETCH with imem_rvalid=1: inst<=imem_rdata, state<=HOLD (zero-wait memory gives one fetch per two cycles).
REQ-019 imem_rvalid outside FETCH SHALL be ignored, with no change to inst or state.
REQ-020 In HOLD: inst_valid=1, imem_req=0; pc and inst SHALL stay stable while inst_ready=0.
REQ-021 In HOLD with inst_ready=1 and npc[1:0]==2'b00: pc<=npc, fetch_cnt<=fetch_cnt+1, state<=FETCH.
REQ-022 In HOLD with inst_ready=1 and npc[1:0]!=2'b00: fetch_cnt increments, pc unchanged, fetch_err<=1, state<=ERR.
REQ-023 ERR SHALL be absorbing until reset: imem_req=0, inst_valid=0, fetch_err=1.
REQ-024 inst_valid SHALL be 1 only in HOLD; imem_req SHALL be 1 only in FETCH.
REQ-025 fetch_cnt SHALL wrap modulo 2^32 from 32'hFFFF_FFFF to 0.
REQ-026 inst_ready outside HOLD SHALL have no effect.
REQ-027 npc SHALL be sampled only on the HOLD accept cycle and need not be stable otherwise.

Reset
REQ-028 While rst_n=0, regardless of clk: state=BOOT, pc=RESET_PC, inst=32'h0000_0013 (NOP), fetch_cnt=0, fetch_err=0, imem_req=0, inst_valid=0.
REQ-029 Reset asserted mid-FETCH SHALL drop imem_req immediately; a later imem_rvalid SHALL be discarded.

Structure
REQ-030 State encodings and RESET_PC default SHALL live in the shared defines header beside the NPC_* opcodes.
REQ-031 The block SHALL be a single module with no sub-modules; imem_req, imem_addr and inst_valid SHALL be decoded from registered state only.

Verification
REQ-032 Reset release, memory always rvalid with rdata=32'h0010_0093, inst_ready=1, npc=pc+4: pc sequence 0,4,8; inst_valid high every other cycle; fetch_cnt=3 after third accept.
REQ-033 Memory asserts rvalid 3 cycles after req: imem_addr held constant for all wait cycles; inst captured only on the rvalid cycle.
REQ-034 inst_ready=0 for 5 cycles in HOLD: pc/inst unchanged, imem_req=0 throughout; accept with npc=32'h0000_0100 gives next imem_addr=32'h0000_0100.
REQ-035 Accept with npc=32'h0000_0102: fetch_err=1 next cycle, imem_req and inst_valid stay 0 forever, fetch_cnt incremented once.
REQ-036 rst_n pulsed low mid-FETCH and mid-ERR: outputs return to reset values asynchronously; first request after release is to RESET_PC.
REQ-037 fetch_cnt forced near 32'hFFFF_FFFE, two accepts: fetch_cnt reads 32'hFFFF_FFFF, then 0.
